// File: rtl/sink_pkg.sv
// Shared types and flit-field geometry for the NoC sink checker and its LFSR.
// Field layout, MSB first: [src | dst | id | seq].
package sink_pkg;

  localparam int ID_WIDTH = 8;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DST  = 2'd1,
    ERR_ID   = 2'd2,
    ERR_SEQ  = 2'd3
  } err_code_e;

  function automatic int seq_width(input int width, input int n_addr_width);
    return width - 2 * n_addr_width - ID_WIDTH;
  endfunction

  function automatic int src_msb(input int width, input int n_addr_width);
    return width - 1 + 0 * n_addr_width;
  endfunction

  function automatic int dst_msb(input int width, input int n_addr_width);
    return width - n_addr_width - 1;
  endfunction

  function automatic int id_msb(input int width, input int n_addr_width);
    return seq_width(width, n_addr_width) + ID_WIDTH - 1;
  endfunction

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loaded with seed while reset is held.
// Also used by the traffic generator for injection-rate control.
module lfsr16
  import sink_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsr16_step(state_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_q;

endmodule

// File: rtl/sink_checker.sv
// NoC output-port sink: accepts flits under valid/ready, checks dst, id and
// per-source sequence order, and keeps saturating accept/error counters.
module sink_checker
  import sink_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          N            = 16,
  parameter int          N_ADDR_WIDTH = $clog2(N),
  parameter int          NODE         = 15,
  parameter int          NUM_SRC      = 4,
  parameter int          DONE_COUNT   = 100,
  parameter int          BP_MODE      = 0,
  parameter logic [15:0] BP_SEED      = 16'hACE1,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] rx_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int SEQ_W     = seq_width(WIDTH, N_ADDR_WIDTH);
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TBL_DEPTH = 2 ** IDX_W;

  localparam logic [N_ADDR_WIDTH-1:0] NODE_L    = N_ADDR_WIDTH'(NODE);
  localparam logic [ID_WIDTH:0]       NUM_SRC_L = (ID_WIDTH + 1)'(NUM_SRC);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]    DONE_L    = CNT_WIDTH'(DONE_COUNT);

  if (SEQ_W < 1) begin : g_seq_w_check
    $error("sink_checker: WIDTH too small, sequence field would be %0d bits", SEQ_W);
  end
  if (NUM_SRC < 1 || NUM_SRC > 256) begin : g_num_src_check
    $error("sink_checker: NUM_SRC must be 1..256, got %0d", NUM_SRC);
  end
  if (BP_SEED == 16'h0000) begin : g_seed_check
    $error("sink_checker: BP_SEED must be nonzero");
  end

  logic [N_ADDR_WIDTH-1:0] dst_f;
  logic [ID_WIDTH-1:0]     id_f;
  logic [SEQ_W-1:0]        seq_f;
  logic [IDX_W-1:0]        id_idx;
  logic                    unused_src;

  // The source field is carried for debug only; it takes no part in checking.
  assign unused_src = ^data_in[src_msb(WIDTH, N_ADDR_WIDTH) -: N_ADDR_WIDTH];
  assign dst_f      = data_in[dst_msb(WIDTH, N_ADDR_WIDTH) -: N_ADDR_WIDTH];
  assign id_f       = data_in[id_msb(WIDTH, N_ADDR_WIDTH) -: ID_WIDTH];
  assign seq_f      = data_in[SEQ_W-1:0];
  assign id_idx     = id_f[IDX_W-1:0];

  logic [15:0] lfsr_state;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (BP_SEED),
    .out  (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[15:1];

  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  err_code_e            err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [SEQ_W-1:0]     exp_seq_q [TBL_DEPTH];
  logic [SEQ_W-1:0]     exp_seq_d [TBL_DEPTH];

  logic                 accept;
  logic                 id_legal;
  logic [SEQ_W-1:0]     exp_rd;
  err_code_e            chk_class;
  logic                 flit_bad;

  assign accept   = valid_in && ready_q;
  assign id_legal = ({1'b0, id_f} < NUM_SRC_L);
  assign exp_rd   = exp_seq_q[id_idx];

  // One verdict per flit; the first failing field in dst > id > seq order wins.
  always_comb begin
    chk_class = ERR_NONE;
    if (dst_f != NODE_L) begin
      chk_class = ERR_DST;
    end else if (!id_legal) begin
      chk_class = ERR_ID;
    end else if (seq_f != exp_rd) begin
      chk_class = ERR_SEQ;
    end
  end

  assign flit_bad = accept && (chk_class != ERR_NONE);

  // Resync to the received seq even on error so a dropped flit costs one error.
  always_comb begin
    exp_seq_d = exp_seq_q;
    if (accept && id_legal) begin
      exp_seq_d[id_idx] = seq_f + SEQ_W'(1);
    end
  end

  always_comb begin
    ready_d     = (BP_MODE == 0) ? 1'b1 : lfsr_state[0];
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    error_d     = error_q | flit_bad;
    err_code_d  = err_code_q;
    if (accept && (rx_count_q != CNT_MAX)) begin
      rx_count_d = rx_count_q + CNT_WIDTH'(1);
    end
    if (flit_bad && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_WIDTH'(1);
    end
    if (flit_bad && (err_code_q == ERR_NONE)) begin
      err_code_d = chk_class;
    end
    done_d = done_q | (rx_count_d >= DONE_L);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      rx_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      ready_q     <= ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        exp_seq_q[i] <= '0;
      end
    end else begin
      exp_seq_q <= exp_seq_d;
    end
  end

  assign ready_out = ready_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;

endmodule
